dma_descriptor_queue: RTL

DMA_DESCRIPTOR_QUEUE -- requirements
Module: dma_descriptor_queue

---
 rtl/dma_descriptor_queue.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dma_descriptor_queue.sv
// CSR-programmed DMA descriptor queue: stages a {src, dest, length} triple and
// pushes it into a show-ahead FIFO consumed via not_empty/rdack.
module dma_descriptor_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          csr_wr_en,
    input  logic [1:0]                    csr_wr_sel,
    input  logic [63:0]                   csr_wr_data,
    input  logic                          csr_clear,
    output logic                          descriptor_fifo_not_empty,
    input  logic                          descriptor_fifo_rdack,
    output logic [2*ADDR_W+LEN_W-1:0]     descriptor,
    output logic [$clog2(DEPTH):0]        fill_count,
    output logic                          overflow_err,
    output logic                          zero_len_err,
    output logic [31:0]                   accepted_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DESC_W = 2 * ADDR_W + LEN_W;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [1:0] SEL_SRC  = 2'd0;
    localparam logic [1:0] SEL_DST  = 2'd1;
    localparam logic [1:0] SEL_LEN  = 2'd2;
    localparam logic [1:0] SEL_PUSH = 2'd3;

    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;

    logic [DESC_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              not_empty_r;
    logic              overflow_err_r;
    logic              zero_len_err_r;
    logic [31:0]       accepted_r;

    logic              push_req_s;
    logic              pop_s;
    logic              push_ok_s;
    logic              ovf_drop_s;
    logic              zlen_drop_s;
    logic [CNT_W-1:0]  count_next_s;

    // Push/pop qualification; a full queue still accepts when the head leaves this cycle.
    always_comb begin
        push_req_s   = 1'b0;
        pop_s        = 1'b0;
        push_ok_s    = 1'b0;
        ovf_drop_s   = 1'b0;
        zlen_drop_s  = 1'b0;
        count_next_s = count_r;
        if (csr_wr_en && (csr_wr_sel == SEL_PUSH)) begin
            push_req_s = 1'b1;
        end else begin
            push_req_s = 1'b0;
        end
        pop_s = descriptor_fifo_rdack && not_empty_r;
        if (push_req_s && (len_r == LEN_W'(0))) begin
            zlen_drop_s = 1'b1;
        end else if (push_req_s && (count_r == FULL_COUNT) && !pop_s) begin
            ovf_drop_s = 1'b1;
        end else begin
            push_ok_s = push_req_s;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Staging registers hold their value across pushes so a descriptor can be re-pushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_r <= '0;
            dst_r <= '0;
            len_r <= '0;
        end else if (csr_clear) begin
            src_r <= '0;
            dst_r <= '0;
            len_r <= '0;
        end else if (csr_wr_en) begin
            case (csr_wr_sel)
                SEL_SRC: src_r <= csr_wr_data[ADDR_W-1:0];
                SEL_DST: dst_r <= csr_wr_data[ADDR_W-1:0];
                SEL_LEN: len_r <= csr_wr_data[LEN_W-1:0];
                default: ;
            endcase
        end
    end

    // Queue control state; clear takes priority over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            not_empty_r    <= 1'b0;
            overflow_err_r <= 1'b0;
            zero_len_err_r <= 1'b0;
            accepted_r     <= 32'd0;
        end else if (csr_clear) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            not_empty_r    <= 1'b0;
            overflow_err_r <= 1'b0;
            zero_len_err_r <= 1'b0;
            accepted_r     <= 32'd0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r   <= wr_ptr_r + PTR_W'(1);
                accepted_r <= accepted_r + 32'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r        <= count_next_s;
            not_empty_r    <= (count_next_s != CNT_W'(0));
            overflow_err_r <= overflow_err_r | ovf_drop_s;
            zero_len_err_r <= zero_len_err_r | zlen_drop_s;
        end
    end

    // Descriptor storage; contents need no reset since not_empty qualifies them.
    always_ff @(posedge clk) begin
        if (push_ok_s && !csr_clear) begin
            mem_r[wr_ptr_r] <= {src_r, dst_r, len_r};
        end
    end

    assign descriptor_fifo_not_empty = not_empty_r;
    assign descriptor                = mem_r[rd_ptr_r];
    assign fill_count                = count_r;
    assign overflow_err              = overflow_err_r;
    assign zero_len_err              = zero_len_err_r;
    assign accepted_count            = accepted_r;

endmodule
